// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority-encoder queue.
//   PRIO_FIXED / PRIO_RR : arbitration mode selectors for RR_MODE
//   clog2()              : ceiling log2 usable in parameter context (minimum 1)
package prio_enc_pkg;

    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

    // Ceiling log2, clamped to 1 so a 2-input queue still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational request picker: first set bit of vec at or after start
// (wrapping past WIDTH-1 to 0) when rr_en, otherwise lowest set bit.
//   vec   : request vector to search
//   start : search origin for round-robin mode
//   rr_en : 1 = round-robin search, 0 = fixed (bit 0 highest)
//   sel   : chosen index (0 when nothing is found)
//   found : vec has at least one set bit
module prio_pick #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_en,
    output logic [IDX_W-1:0] sel,
    output logic             found
);

    logic [2*WIDTH-1:0] dbl;

    // Doubling the vector is the rotation: the window [base, base+WIDTH)
    // is the vector rotated by base, and folding the hit back by WIDTH
    // un-rotates it. Scanning downwards lets the lowest hit win.
    always_comb begin
        int base;
        dbl   = {vec, vec};
        base  = rr_en ? int'(start) : 0;
        sel   = '0;
        found = 1'b0;
        for (int i = int'(2 * WIDTH) - 1; i >= 0; i--) begin
            if (i >= base && i < base + int'(WIDTH) && dbl[i]) begin
                found = 1'b1;
                sel   = IDX_W'((i >= int'(WIDTH)) ? i - int'(WIDTH) : i);
            end
        end
    end

endmodule

// File: rtl/prio_enc_queue.sv
// Sticky request collector with one-at-a-time grant issue over valid/ready.
//   clk, rst    : clock, synchronous active-high reset
//   req_in      : request bits, each sets its pending bit
//   clear_all   : flush pending (same-cycle requests dropped, output untouched)
//   out_ready   : consumer accepts the current grant
//   out_valid   : out_idx holds a granted request
//   out_idx     : granted request index
//   pending     : registered pending vector
//   any_pending : registered OR of pending
module prio_enc_queue
    import prio_enc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned IDX_W   = clog2(WIDTH),
    parameter int unsigned RR_MODE = PRIO_FIXED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic             clear_all,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending
);

    localparam bit RR_EN = (RR_MODE == PRIO_RR);

    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] clr_mask;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] sel;
    logic             valid_q;
    logic             any_q;
    logic             found;
    logic             load;

    // Selection looks only at the registered pending vector.
    prio_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec   (pending_q),
        .start (ptr_q),
        .rr_en (RR_EN),
        .sel   (sel),
        .found (found)
    );

    // Load when the output slot is free or being freed this cycle.
    always_comb begin
        load         = (!valid_q || out_ready) && found && !clear_all;
        clr_mask     = load ? (WIDTH'(1) << sel) : '0;
        // OR-ing req_in after the clear makes a coincident request re-set the bit.
        pending_next = clear_all ? '0 : ((pending_q & ~clr_mask) | req_in);
        ptr_next     = (sel == IDX_W'(WIDTH - 1)) ? '0 : sel + IDX_W'(1);
    end

    // Pending, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            any_q     <= 1'b0;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_next;
            any_q     <= |pending_next;
            if (load) begin
                valid_q <= 1'b1;
                idx_q   <= sel;
                ptr_q   <= ptr_next;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_idx     = idx_q;
    assign pending     = pending_q;
    assign any_pending = any_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Randomised and directed bench for prio_enc_queue: fixed-mode and RR-mode
// 8-wide instances plus a 5-wide RR instance, all against a queue model.
module tb_prio_enc_queue;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       clr;
    logic       rdy;

    logic       v0, v1, v2;
    logic [2:0] i0, i1, i2;
    logic [7:0] p0, p1;
    logic [4:0] p2;
    logic       a0, a1, a2;

    int n_tests = 0;
    int n_fail  = 0;

    int          W  [3] = '{8, 8, 5};
    bit          RR [3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] m_pend  [3];
    bit          m_valid [3];
    int          m_idx   [3];
    int          m_ptr   [3];

    prio_enc_queue #(.WIDTH(8), .RR_MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .req_in(req), .clear_all(clr), .out_ready(rdy),
        .out_valid(v0), .out_idx(i0), .pending(p0), .any_pending(a0)
    );

    prio_enc_queue #(.WIDTH(8), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req_in(req), .clear_all(clr), .out_ready(rdy),
        .out_valid(v1), .out_idx(i1), .pending(p1), .any_pending(a1)
    );

    prio_enc_queue #(.WIDTH(5), .RR_MODE(1)) dut_rr5 (
        .clk(clk), .rst(rst), .req_in(req[4:0]), .clear_all(clr), .out_ready(rdy),
        .out_valid(v2), .out_idx(i2), .pending(p2), .any_pending(a2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pending is a set of indices; each accepted slot takes the
    // first member found walking from the pointer (or from 0 in fixed mode).
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int          w;
            logic [63:0] msk;
            bit          fnd;
            bit          ld;
            int          s;
            w   = W[d];
            msk = (64'(1) << w) - 64'(1);
            if (rst) begin
                m_pend[d]  = '0;
                m_valid[d] = 1'b0;
                m_idx[d]   = 0;
                m_ptr[d]   = 0;
            end else begin
                fnd = 1'b0;
                s   = 0;
                for (int k = 0; k < w; k++) begin
                    int j;
                    j = RR[d] ? (m_ptr[d] + k) % w : k;
                    if (!fnd && m_pend[d][j]) begin
                        fnd = 1'b1;
                        s   = j;
                    end
                end
                ld = (!m_valid[d] || rdy) && fnd && !clr;
                if (clr) begin
                    m_pend[d] = '0;
                end else begin
                    if (ld) m_pend[d][s] = 1'b0;
                    m_pend[d] = m_pend[d] | (64'(req) & msk);
                end
                if (ld) begin
                    m_valid[d] = 1'b1;
                    m_idx[d]   = s;
                    m_ptr[d]   = (s + 1) % w;
                end else if (rdy) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic v, input logic [63:0] idx,
                             input logic [63:0] p, input logic a);
        check($sformatf("d%0d_valid", d), 64'(v), 64'(m_valid[d]));
        check($sformatf("d%0d_idx", d), idx, 64'(m_idx[d]));
        check($sformatf("d%0d_pending", d), p, m_pend[d]);
        check($sformatf("d%0d_any", d), 64'(a), 64'(|m_pend[d]));
    endtask

    task automatic tick(input logic [7:0] r, input logic c, input logic rd, input logic rs);
        req = r;
        clr = c;
        rdy = rd;
        rst = rs;
        @(posedge clk);
        model_step();
        #1;
        check_dut(0, v0, 64'(i0), 64'(p0), a0);
        check_dut(1, v1, 64'(i1), 64'(p1), a1);
        check_dut(2, v2, 64'(i2), 64'(p2), a2);
    endtask

    int seq [3] = '{0, 1, 7};

    initial begin
        req = '0; clr = 1'b0; rdy = 1'b0; rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_pend[d] = '0; m_valid[d] = 1'b0; m_idx[d] = 0; m_ptr[d] = 0;
        end

        // Reset and idle.
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(8'h00, 1'b0, 1'b0, 1'b0);
            check("idle_valid", 64'(v0), 64'd0);
            check("idle_pending", 64'(p0), 64'd0);
        end

        // Fixed-priority drain of a single pulse.
        tick(8'hA4, 1'b0, 1'b1, 1'b0);
        check("drain_pend", 64'(p0), 64'hA4);
        check("drain_v0", 64'(v0), 64'd0);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("drain_i1", 64'(i0), 64'd2);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("drain_i2", 64'(i0), 64'd5);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("drain_i3", 64'(i0), 64'd7);
        check("drain_v3", 64'(v0), 64'd1);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("drain_end_v", 64'(v0), 64'd0);
        check("drain_end_p", 64'(p0), 64'd0);

        // Round-robin fairness with requests held.
        tick(8'h00, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(8'h83, 1'b0, 1'b1, 1'b0);
            if (k >= 1) begin
                check("rr_valid", 64'(v1), 64'd1);
                check("rr_idx", 64'(i1), 64'(seq[(k - 1) % 3]));
            end
        end
        for (int k = 0; k < 4; k++) tick(8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure holds the grant.
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        tick(8'h12, 1'b0, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(8'h00, 1'b0, 1'b0, 1'b0);
            check("bp_valid", 64'(v0), 64'd1);
            check("bp_idx", 64'(i0), 64'd1);
        end
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_next_idx", 64'(i0), 64'd4);

        // Request colliding with its own grant re-sets the bit.
        tick(8'h00, 1'b0, 1'b1, 1'b1);
        tick(8'h08, 1'b0, 1'b1, 1'b0);
        tick(8'h08, 1'b0, 1'b1, 1'b0);
        check("sw_idx", 64'(i0), 64'd3);
        check("sw_pend3", 64'(p0[3]), 64'd1);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("sw_regrant", 64'(i0), 64'd3);
        check("sw_regrant_v", 64'(v0), 64'd1);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("sw_done", 64'(v0), 64'd0);

        // Flush keeps the held grant and drops same-cycle requests.
        tick(8'h00, 1'b0, 1'b0, 1'b1);
        tick(8'hF0, 1'b0, 1'b0, 1'b0);
        tick(8'hF0, 1'b0, 1'b0, 1'b0);
        check("fl_pre_pend", 64'(p0), 64'hF0);
        tick(8'h01, 1'b1, 1'b0, 1'b0);
        check("fl_pend", 64'(p0), 64'd0);
        check("fl_any", 64'(a0), 64'd0);
        check("fl_idx", 64'(i0), 64'd4);
        tick(8'h00, 1'b0, 1'b0, 1'b0);
        check("fl_hold", 64'(i0), 64'd4);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("fl_done", 64'(v0), 64'd0);
        tick(8'h00, 1'b0, 1'b1, 1'b0);
        check("fl_no_grant0", 64'(v0), 64'd0);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            tick(8'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
